// File: rtl/vga_axil_pkg.sv
// -----------------------------------------------------------------------------
// vga_axil_pkg
// Shared types for the VGA AXI4-Lite slave front end:
//   axil_addr_t / axil_data_t / axil_strb_t : AXI-Lite bus fields
//   native_addr_t                           : native-side word address
//   axil_resp_e                             : AXI response codes used here
//   bridge_state_e                          : transaction sequencer states
//   prio_e                                  : read/write arbitration priority
// -----------------------------------------------------------------------------
package vga_axil_pkg;

  localparam int VGA_AXIL_AW   = 32;
  localparam int VGA_AXIL_DW   = 32;
  localparam int VGA_NATIVE_AW = 10;

  typedef logic [VGA_AXIL_AW-1:0]   axil_addr_t;
  typedef logic [VGA_AXIL_DW-1:0]   axil_data_t;
  typedef logic [VGA_AXIL_DW/8-1:0] axil_strb_t;
  typedef logic [VGA_NATIVE_AW-1:0] native_addr_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axil_resp_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_EXEC = 3'd1,
    WR_RESP = 3'd2,
    RD_EXEC = 3'd3,
    RD_WAIT = 3'd4,
    RD_RESP = 3'd5
  } bridge_state_e;

  typedef enum logic {
    PRIO_WRITE = 1'b0,
    PRIO_READ  = 1'b1
  } prio_e;

  // A write is only performed on the native side when every byte lane is set.
  function automatic logic strb_full(input axil_strb_t strb);
    return &strb;
  endfunction

endpackage

// File: rtl/vga_axil_wr_collect.sv
// -----------------------------------------------------------------------------
// vga_axil_wr_collect
// Collects the AXI-Lite AW and W channels, which may complete in either order
// or together, into one joined write request.
//   clk, rst            : clock, synchronous active-high reset
//   accept              : sequencer allows AW/W handshakes this cycle
//   clr                 : drop both held halves (write response accepted)
//   s_aw*, s_w*         : AXI-Lite write address / data channels
//   aw_hold, w_hold     : which halves are currently held
//   req_join            : both halves are held or complete on this edge
//   req_addr            : held byte address, bits [AW-1:2]
//   req_data, req_strb  : held write data and strobes
// -----------------------------------------------------------------------------
module vga_axil_wr_collect
  import vga_axil_pkg::*;
#(
  parameter int AXIL_AW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               accept,
  input  logic               clr,
  input  logic [AXIL_AW-1:0] s_awaddr,
  input  logic               s_awvalid,
  output logic               s_awready,
  input  axil_data_t         s_wdata,
  input  axil_strb_t         s_wstrb,
  input  logic               s_wvalid,
  output logic               s_wready,
  output logic               aw_hold,
  output logic               w_hold,
  output logic               req_join,
  output logic [AXIL_AW-3:0] req_addr,
  output axil_data_t         req_data,
  output axil_strb_t         req_strb
);

  logic aw_hs;
  logic w_hs;

  // Byte-lane bits never reach the native word address.
  logic unused_awaddr_lsb;
  assign unused_awaddr_lsb = ^s_awaddr[1:0];

  assign s_awready = accept && !aw_hold && !rst;
  assign s_wready  = accept && !w_hold && !rst;
  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid && s_wready;

  // Lets the sequencer leave IDLE on the same edge the last half arrives.
  assign req_join  = (aw_hold || aw_hs) && (w_hold || w_hs);

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_hold  <= 1'b0;
      w_hold   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      req_strb <= '0;
    end else if (clr) begin
      aw_hold <= 1'b0;
      w_hold  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_hold  <= 1'b1;
        req_addr <= s_awaddr[AXIL_AW-1:2];
      end
      if (w_hs) begin
        w_hold   <= 1'b1;
        req_data <= s_wdata;
        req_strb <= s_wstrb;
      end
    end
  end

endmodule

// File: rtl/vga_axil2native.sv
// -----------------------------------------------------------------------------
// vga_axil2native
// AXI4-Lite slave front end of the VGA register/framebuffer path. Executes one
// AXI-Lite transaction at a time as a single native strobe.
//   clk, rst               : clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*        : AXI-Lite write address, data, response channels
//   s_ar*/s_r*             : AXI-Lite read address and data channels
//   addr_write, data2native, write_en : native write (one-clock strobe)
//   addr_read, read_en_sync           : native read (one-clock strobe)
//   data2axil              : native read data, valid the cycle after the strobe
// Reads and writes arbitrate round-robin when both arrive in the same cycle.
// -----------------------------------------------------------------------------
module vga_axil2native
  import vga_axil_pkg::*;
#(
  parameter int AXIL_AW   = 32,
  parameter int AXIL_DW   = 32,
  parameter int NATIVE_AW = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AXIL_AW-1:0]     s_awaddr,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [AXIL_DW-1:0]     s_wdata,
  input  logic [AXIL_DW/8-1:0]   s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [AXIL_AW-1:0]     s_araddr,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [AXIL_DW-1:0]     s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic [NATIVE_AW-1:0]   addr_write,
  output logic [AXIL_DW-1:0]     data2native,
  output logic                   write_en,
  output logic [NATIVE_AW-1:0]   addr_read,
  output logic                   read_en_sync,
  input  logic [AXIL_DW-1:0]     data2axil
);

  bridge_state_e state, state_next;
  prio_e         prio;

  logic               aw_hold, w_hold, req_join;
  logic [AXIL_AW-3:0] req_addr;
  axil_data_t         req_data;
  axil_strb_t         req_strb;
  logic               wr_accept, wr_clr;
  logic               none_held, conflict, in_idle;
  logic               ar_hs;
  logic [AXIL_AW-3:0] ar_addr_q;
  logic               wr_in_range, wr_ok, rd_in_range;
  axil_resp_e         bresp_q, rresp_q;

  logic unused_araddr_lsb;
  assign unused_araddr_lsb = ^s_araddr[1:0];

  // ---------------------------------------------------------------------------
  // Arbitration: a fresh write and a fresh read in the same cycle are granted
  // according to prio; once either write half is held, reads wait.
  // ---------------------------------------------------------------------------
  assign in_idle   = (state == IDLE);
  assign none_held = !aw_hold && !w_hold;
  assign conflict  = none_held && s_arvalid && (s_awvalid || s_wvalid);
  assign wr_accept = in_idle && !(conflict && (prio == PRIO_READ));
  assign s_arready = in_idle && none_held && !rst && !(conflict && (prio == PRIO_WRITE));
  assign ar_hs     = s_arvalid && s_arready;

  vga_axil_wr_collect #(
    .AXIL_AW (AXIL_AW)
  ) u_wr_collect (
    .clk       (clk),
    .rst       (rst),
    .accept    (wr_accept),
    .clr       (wr_clr),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .aw_hold   (aw_hold),
    .w_hold    (w_hold),
    .req_join  (req_join),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_strb  (req_strb)
  );

  // Address decode on the held word addresses (byte lanes already dropped).
  assign wr_in_range = (req_addr[AXIL_AW-3:NATIVE_AW] == '0);
  assign wr_ok       = wr_in_range && strb_full(req_strb);
  assign rd_in_range = (ar_addr_q[AXIL_AW-3:NATIVE_AW] == '0);

  assign addr_write  = req_addr[NATIVE_AW-1:0];
  assign data2native = req_data;
  assign addr_read   = ar_addr_q[NATIVE_AW-1:0];
  assign s_bresp     = bresp_q;
  assign s_rresp     = rresp_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    write_en     = 1'b0;
    read_en_sync = 1'b0;
    s_bvalid     = 1'b0;
    s_rvalid     = 1'b0;
    wr_clr       = 1'b0;
    case (state)
      IDLE: begin
        if (ar_hs)         state_next = RD_EXEC;
        else if (req_join) state_next = WR_EXEC;
      end
      WR_EXEC: begin
        write_en   = wr_ok && !rst;
        state_next = WR_RESP;
      end
      WR_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) begin
          wr_clr     = 1'b1;
          state_next = IDLE;
        end
      end
      RD_EXEC: begin
        read_en_sync = rd_in_range && !rst;
        state_next   = RD_WAIT;
      end
      RD_WAIT: state_next = RD_RESP;
      RD_RESP: begin
        s_rvalid = 1'b1;
        if (s_rready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response registers: write response settles in WR_EXEC, read data is taken
  // from the native side in RD_WAIT (one cycle after the read strobe).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= PRIO_WRITE;
      ar_addr_q <= '0;
      s_rdata   <= '0;
      bresp_q   <= OKAY;
      rresp_q   <= OKAY;
    end else begin
      if (ar_hs) ar_addr_q <= s_araddr[AXIL_AW-1:2];
      if (state == WR_EXEC) bresp_q <= wr_ok ? OKAY : SLVERR;
      if (state == RD_WAIT) begin
        s_rdata <= rd_in_range ? data2axil : '0;
        rresp_q <= rd_in_range ? OKAY : SLVERR;
      end
      if (state == WR_RESP && s_bready) prio <= PRIO_READ;
      if (state == RD_RESP && s_rready) prio <= PRIO_WRITE;
    end
  end

endmodule

// File: tb/tb_vga_axil2native.sv
module tb_vga_axil2native;

  logic        clk;
  logic        rst;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [9:0]  addr_write;
  logic [31:0] data2native;
  logic        write_en;
  logic [9:0]  addr_read;
  logic        read_en_sync;
  logic [31:0] data2axil = 32'h0;

  int errors = 0;
  int checks = 0;

  int wr_cnt = 0, rd_cnt = 0, overlap = 0, dbl = 0;
  logic prev_we = 1'b0, prev_re = 1'b0;
  logic [31:0] rd_value = 32'h0;

  vga_axil2native dut (
    .clk          (clk),
    .rst          (rst),
    .s_awaddr     (s_awaddr),
    .s_awvalid    (s_awvalid),
    .s_awready    (s_awready),
    .s_wdata      (s_wdata),
    .s_wstrb      (s_wstrb),
    .s_wvalid     (s_wvalid),
    .s_wready     (s_wready),
    .s_bresp      (s_bresp),
    .s_bvalid     (s_bvalid),
    .s_bready     (s_bready),
    .s_araddr     (s_araddr),
    .s_arvalid    (s_arvalid),
    .s_arready    (s_arready),
    .s_rdata      (s_rdata),
    .s_rresp      (s_rresp),
    .s_rvalid     (s_rvalid),
    .s_rready     (s_rready),
    .addr_write   (addr_write),
    .data2native  (data2native),
    .write_en     (write_en),
    .addr_read    (addr_read),
    .read_en_sync (read_en_sync),
    .data2axil    (data2axil)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Native memory stand-in: returns rd_value only in the cycle after a read
  // strobe, and a poison pattern at every other time.
  always @(posedge clk) data2axil <= read_en_sync ? rd_value : 32'hBAD0_BAD0;

  // Strobe monitor.
  always @(negedge clk) begin
    if (write_en) wr_cnt <= wr_cnt + 1;
    if (read_en_sync) rd_cnt <= rd_cnt + 1;
    if (write_en && read_en_sync) overlap <= overlap + 1;
    if ((write_en && prev_we) || (read_en_sync && prev_re)) dbl <= dbl + 1;
    prev_we <= write_en;
    prev_re <= read_en_sync;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents AW and/or W; returns #1 after the edge of the last handshake.
  task automatic wr_req(input logic aw_en, input logic [31:0] a,
                        input logic w_en, input logic [31:0] d, input logic [3:0] st);
    logic aw_go, w_go;
    s_awvalid = aw_en; s_awaddr = a;
    s_wvalid  = w_en;  s_wdata  = d; s_wstrb = st;
    for (int i = 0; i < 20 && (s_awvalid || s_wvalid); i++) begin
      @(negedge clk);
      aw_go = s_awvalid && s_awready;
      w_go  = s_wvalid && s_wready;
      @(posedge clk);
      #1;
      if (aw_go) s_awvalid = 1'b0;
      if (w_go)  s_wvalid  = 1'b0;
    end
    chk("wr_req_handshake", {s_awvalid, s_wvalid}, 2'b00);
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
  endtask

  task automatic rd_req(input logic [31:0] a);
    logic go;
    go = 1'b0;
    s_arvalid = 1'b1; s_araddr = a;
    for (int i = 0; i < 20 && !go; i++) begin
      @(negedge clk);
      go = s_arready;
      @(posedge clk);
      #1;
    end
    s_arvalid = 1'b0;
    chk("rd_req_handshake", go, 1'b1);
  endtask

  task automatic b_take(output logic [1:0] r);
    logic got;
    got = 1'b0; r = 2'bxx;
    s_bready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (s_bvalid) begin got = 1'b1; r = s_bresp; end
      @(posedge clk);
      #1;
    end
    s_bready = 1'b0;
    chk("b_handshake", got, 1'b1);
  endtask

  task automatic r_take(output logic [1:0] r, output logic [31:0] d);
    logic got;
    got = 1'b0; r = 2'bxx; d = 'x;
    s_rready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (s_rvalid) begin got = 1'b1; r = s_rresp; d = s_rdata; end
      @(posedge clk);
      #1;
    end
    s_rready = 1'b0;
    chk("r_handshake", got, 1'b1);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          snap;
    int          order [8];
    int          n;
    logic        b_done, r_done, ar_go, aw_go, w_go;

    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    n = 0;
    repeat (3) tick();

    // Reset state
    chk("rst_readies", {s_awready, s_wready, s_arready}, 3'b000);
    chk("rst_strobes", {write_en, read_en_sync}, 2'b00);
    chk("rst_valids", {s_bvalid, s_rvalid}, 2'b00);
    chk("rst_regs", {s_rdata, s_bresp, s_rresp, addr_write, addr_read}, 0);
    chk("rst_data2native", data2native, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_readies", {s_awready, s_wready, s_arready}, 3'b111);

    // Single write, AW and W together
    wr_req(1'b1, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
    chk("w1_write_en", write_en, 1'b1);
    chk("w1_addr_write", addr_write, 10'd4);
    chk("w1_data2native", data2native, 32'hDEADBEEF);
    tick();
    chk("w1_strobe_gone", write_en, 1'b0);
    chk("w1_bvalid", {s_bvalid, s_bresp}, 3'b100);
    b_take(resp);
    chk("w1_bresp", resp, 2'b00);
    chk("w1_bvalid_clear", s_bvalid, 1'b0);
    chk("w1_count", wr_cnt, 1);

    // W three cycles ahead of AW
    wr_req(1'b0, 32'h0, 1'b1, 32'hCAFE0001, 4'hF);
    for (int i = 0; i < 3; i++) begin
      chk("w2_no_early_strobe", {write_en, s_wready}, 2'b00);
      tick();
    end
    chk("w2_count_before_aw", wr_cnt, 1);
    wr_req(1'b1, 32'h0FFC, 1'b0, 32'h0, 4'h0);
    chk("w2_write_en", write_en, 1'b1);
    chk("w2_addr_write", addr_write, 10'h3FF);
    chk("w2_data2native", data2native, 32'hCAFE0001);
    b_take(resp);
    chk("w2_bresp", resp, 2'b00);

    // Read with 5 cycles of rready backpressure
    rd_value = 32'h12345678;
    rd_req(32'h20);
    chk("r1_read_en", read_en_sync, 1'b1);
    chk("r1_addr_read", addr_read, 10'd8);
    tick();
    chk("r1_wait", {read_en_sync, s_rvalid}, 2'b00);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("r1_hold", {s_rvalid, s_rdata, s_rresp}, {1'b1, 32'h12345678, 2'b00});
      tick();
    end
    r_take(resp, rd);
    chk("r1_rdata", rd, 32'h12345678);
    chk("r1_rresp", resp, 2'b00);
    chk("r1_count", rd_cnt, 1);

    // Out-of-range write
    wr_req(1'b1, 32'h1000, 1'b1, 32'h11111111, 4'hF);
    chk("e1_no_write_en", write_en, 1'b0);
    b_take(resp);
    chk("e1_bresp", resp, 2'b10);

    // Partial strobe
    wr_req(1'b1, 32'h0, 1'b1, 32'h22222222, 4'h3);
    chk("e2_no_write_en", write_en, 1'b0);
    b_take(resp);
    chk("e2_bresp", resp, 2'b10);
    chk("e_wr_count", wr_cnt, 2);

    // Out-of-range read, same latency, zero data
    rd_value = 32'h55AA55AA;
    rd_req(32'h2000);
    chk("e3_no_read_en", read_en_sync, 1'b0);
    tick();
    chk("e3_wait", s_rvalid, 1'b0);
    tick();
    chk("e3_rvalid_latency", s_rvalid, 1'b1);
    r_take(resp, rd);
    chk("e3_rdata", rd, 32'h0);
    chk("e3_rresp", resp, 2'b10);
    chk("e3_rd_count", rd_cnt, 1);

    // Simultaneous AR and AW+W after reset, four rounds
    rst = 1'b1; tick(); rst = 1'b0; tick();
    rd_value = 32'h0BADF00D;
    for (int round = 0; round < 4; round++) begin
      s_arvalid = 1'b1; s_araddr = 32'h40;
      s_awvalid = 1'b1; s_awaddr = 32'h44;
      s_wvalid  = 1'b1; s_wdata  = 32'hA0 + round; s_wstrb = 4'hF;
      s_bready  = 1'b1; s_rready = 1'b1;
      b_done = 1'b0; r_done = 1'b0;
      for (int i = 0; i < 40 && !(b_done && r_done); i++) begin
        @(negedge clk);
        ar_go = s_arvalid && s_arready;
        aw_go = s_awvalid && s_awready;
        w_go  = s_wvalid && s_wready;
        if (ar_go && n < 8) begin order[n] = 1; n++; end
        if (aw_go && n < 8) begin order[n] = 0; n++; end
        if (s_bvalid) b_done = 1'b1;
        if (s_rvalid) r_done = 1'b1;
        @(posedge clk);
        #1;
        if (ar_go) s_arvalid = 1'b0;
        if (aw_go) s_awvalid = 1'b0;
        if (w_go)  s_wvalid  = 1'b0;
      end
      chk("arb_round_done", {b_done, r_done}, 2'b11);
      s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
      s_bready = 1'b0; s_rready = 1'b0;
      tick();
    end
    chk("arb_grant_count", n, 8);
    for (int i = 0; i < 8; i++) chk("arb_grant_order", order[i], i % 2);

    // Reset during RD_WAIT
    rd_req(32'h30);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_rd_readies_forced", {s_awready, s_wready, s_arready}, 3'b000);
    tick();
    chk("rst_rd_after", {s_rvalid, s_bvalid, read_en_sync, write_en}, 4'b0000);
    chk("rst_rd_rdata", s_rdata, 32'h0);
    rst = 1'b0;
    snap = rd_cnt;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_rd_no_resume", {s_rvalid, read_en_sync}, 2'b00);
    end
    chk("rst_rd_idle", s_arready, 1'b1);
    chk("rst_rd_strobe_count", rd_cnt, snap);

    // Reset during WR_RESP
    wr_req(1'b1, 32'h50, 1'b1, 32'h33333333, 4'hF);
    chk("rst_wr_exec", write_en, 1'b1);
    tick();
    chk("rst_wr_bvalid", s_bvalid, 1'b1);
    rst = 1'b1;
    tick();
    chk("rst_wr_after", {s_bvalid, s_rvalid, write_en, read_en_sync}, 4'b0000);
    rst = 1'b0;
    tick();
    chk("rst_wr_holds_cleared", {s_awready, s_wready}, 2'b11);

    // Normal write after reset
    snap = wr_cnt;
    wr_req(1'b1, 32'h60, 1'b1, 32'h44444444, 4'hF);
    chk("post_write_en", write_en, 1'b1);
    chk("post_addr_write", addr_write, 10'h18);
    chk("post_data2native", data2native, 32'h44444444);
    b_take(resp);
    chk("post_bresp", resp, 2'b00);
    chk("post_count", wr_cnt, snap + 1);

    tick();
    chk("strobe_overlap", overlap, 0);
    chk("strobe_width", dbl, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
